// File: rtl/sha2_result_checker.sv
// Result checker for the double-SHA256 pipeline: tags each digest with its nonce,
// compares the byte-reversed hash against a target and queues hits in a small FIFO.
module sha2_result_checker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [31:0]  nonce_base,
  input  logic [255:0] target,
  input  logic         valid_in,
  input  logic [255:0] digest_in,
  output logic         hit_valid,
  input  logic         hit_ready,
  output logic [31:0]  hit_nonce,
  output logic [255:0] hit_digest,
  output logic         overflow,
  output logic [31:0]  hash_count,
  output logic [15:0]  hit_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  function automatic logic [255:0] byte_rev(input logic [255:0] d);
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = d[8*(31-k) +: 8];
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0]    nonce_q;
  logic [31:0]    tag_nonce;
  logic           vld_p1;
  logic [31:0]    nonce_p1;
  logic [255:0]   digest_p1;
  logic [255:0]   hash_p2;
  logic           hit_p2;
  logic           push_req;
  logic           push;
  logic           pop;
  logic           full;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [287:0]   mem [DEPTH];

  assign tag_nonce = start ? nonce_base : nonce_q;

  // Stage 1: nonce tagging and digest capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nonce_q    <= '0;
      vld_p1     <= 1'b0;
      nonce_p1   <= '0;
      digest_p1  <= '0;
      hash_count <= '0;
    end else begin
      if (start)
        nonce_q <= valid_in ? nonce_base + 32'd1 : nonce_base;
      else if (valid_in)
        nonce_q <= nonce_q + 32'd1;
      vld_p1 <= valid_in;
      if (valid_in) begin
        nonce_p1  <= tag_nonce;
        digest_p1 <= digest_in;
      end
      if (start)
        hash_count <= valid_in ? 32'd1 : 32'd0;
      else if (valid_in)
        hash_count <= hash_count + 32'd1;
    end
  end

  // Stage 2: Bitcoin byte order and target compare; a start discards this entry
  assign hash_p2  = byte_rev(digest_p1);
  assign hit_p2   = vld_p1 && (hash_p2 < target);
  assign push_req = hit_p2 && !start;
  assign full     = (count == FULL_CNT);
  assign hit_valid = (count != '0);
  assign pop      = hit_valid && hit_ready;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      hit_count <= '0;
    end else if (start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      hit_count <= '0;
    end else begin
      if (push_req) hit_count <= sat_inc16(hit_count);
      if (push_req && !push) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the outputs are masked while the FIFO is empty
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {nonce_p1, digest_p1};
  end

  assign hit_nonce  = hit_valid ? mem[rd_ptr][287:256] : 32'd0;
  assign hit_digest = hit_valid ? mem[rd_ptr][255:0]   : 256'd0;

endmodule
